// File: rtl/time_glyph_streamer.sv
// rtl/time_glyph_streamer.sv - renders a snapshot of hr/min/sec as "HH:MM:SS" 5x7 font column bytes on a valid/ready stream.
// Optional COLON_BLINK_EN: both colons render blank when the snapshot seconds value is odd.
module time_glyph_streamer #(
  parameter int GAP_COLS     = 1,
  parameter int LEADING_ZERO = 1
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       sec_inc,
  input  logic [6:0] hr,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  input  logic       byte_ready,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy
);

  localparam int         COLS_PER_CHAR = 5 + GAP_COLS;
  localparam logic [2:0] LAST_COL      = 3'(COLS_PER_CHAR - 1);
  localparam logic [3:0] G_COLON       = 4'd10;
  localparam logic [3:0] G_DASH        = 4'd11;
  localparam logic [3:0] G_BLANK       = 4'd12;

  typedef enum logic [1:0] {IDLE, CONVERT, STREAM, DONE} state_t;

  state_t     state, state_nxt;
  logic       pending;
  logic [3:0] conv_cnt;
  logic [6:0] field_in [3];
  logic [6:0] snap [3];
  logic [6:0] rem [3];
  logic [3:0] tens [3];
  logic [2:0] char_idx, col_idx;
  logic [2:0] nxt_char, nxt_col;
  logic [6:0] sel_val;
  logic [3:0] sel_tens, sel_ones;
  logic [3:0] glyph;
  logic [7:0] nxt_byte;
  logic       colon_on;
  logic       start, accept, last_byte;

  assign field_in[0] = hr;
  assign field_in[1] = min;
  assign field_in[2] = sec;

  assign start     = sec_inc | pending;
  assign accept    = byte_valid & byte_ready;
  assign last_byte = (char_idx == 3'd7) && (col_idx == LAST_COL);

`ifdef COLON_BLINK_EN
  assign colon_on = ~snap[2][0];
`else
  assign colon_on = 1'b1;
`endif

  function automatic logic [7:0] font_col(input logic [3:0] g, input logic [2:0] c);
    logic [39:0] cols;
    case (g)
      4'd0:    cols = 40'h3E5149453E;
      4'd1:    cols = 40'h00427F4000;
      4'd2:    cols = 40'h4261514946;
      4'd3:    cols = 40'h2141454B31;
      4'd4:    cols = 40'h1814127F10;
      4'd5:    cols = 40'h2745454539;
      4'd6:    cols = 40'h3C4A494930;
      4'd7:    cols = 40'h0171090503;
      4'd8:    cols = 40'h3649494936;
      4'd9:    cols = 40'h064949291E;
      G_COLON: cols = 40'h0036360000;
      G_DASH:  cols = 40'h0808080808;
      default: cols = 40'h0000000000;
    endcase
    font_col = 8'h00;
    case (c)
      3'd0:    font_col = cols[39:32];
      3'd1:    font_col = cols[31:24];
      3'd2:    font_col = cols[23:16];
      3'd3:    font_col = cols[15:8];
      3'd4:    font_col = cols[7:0];
      default: font_col = 8'h00;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CONVERT;
      end
      CONVERT: if (conv_cnt == 4'd9) state_nxt = STREAM;
      STREAM:  if (accept && last_byte) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // IDLE always consumes a pending request, so clearing there is safe.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)               pending <= 1'b0;
    else if (state == IDLE)  pending <= 1'b0;
    else if (sec_inc)        pending <= 1'b1;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      conv_cnt <= 4'd0;
      for (int k = 0; k < 3; k++) begin
        snap[k] <= 7'd0;
        rem[k]  <= 7'd0;
        tens[k] <= 4'd0;
      end
    end else if (state == IDLE && start) begin
      conv_cnt <= 4'd0;
      for (int k = 0; k < 3; k++) begin
        snap[k] <= field_in[k];
        rem[k]  <= field_in[k];
        tens[k] <= 4'd0;
      end
    end else if (state == CONVERT) begin
      conv_cnt <= conv_cnt + 4'd1;
      for (int k = 0; k < 3; k++) begin
        if (rem[k] >= 7'd10 && tens[k] != 4'd9) begin
          rem[k]  <= rem[k] - 7'd10;
          tens[k] <= tens[k] + 4'd1;
        end
      end
    end
  end

  // Position of the byte to load next; an empty output register primes byte 0.
  always_comb begin
    nxt_char = char_idx;
    nxt_col  = col_idx;
    if (!byte_valid) begin
      nxt_char = 3'd0;
      nxt_col  = 3'd0;
    end else if (col_idx == LAST_COL) begin
      nxt_char = char_idx + 3'd1;
      nxt_col  = 3'd0;
    end else begin
      nxt_col = col_idx + 3'd1;
    end
  end

  always_comb begin
    sel_val  = snap[0];
    sel_tens = tens[0];
    sel_ones = rem[0][3:0];
    if (nxt_char >= 3'd6) begin
      sel_val  = snap[2];
      sel_tens = tens[2];
      sel_ones = rem[2][3:0];
    end else if (nxt_char >= 3'd3) begin
      sel_val  = snap[1];
      sel_tens = tens[1];
      sel_ones = rem[1][3:0];
    end
    if (nxt_char == 3'd2 || nxt_char == 3'd5)
      glyph = colon_on ? G_COLON : G_BLANK;
    else if (sel_val >= 7'd100)
      glyph = G_DASH;
    else if (nxt_char == 3'd0 || nxt_char == 3'd3 || nxt_char == 3'd6)
      glyph = (nxt_char == 3'd0 && sel_tens == 4'd0 && LEADING_ZERO == 0) ? G_BLANK : sel_tens;
    else
      glyph = sel_ones;
  end

  assign nxt_byte = font_col(glyph, nxt_col);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      byte_data   <= 8'h00;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      char_idx    <= 3'd0;
      col_idx     <= 3'd0;
    end else if (state == STREAM) begin
      if (!byte_valid || (byte_ready && !last_byte)) begin
        byte_valid  <= 1'b1;
        byte_data   <= nxt_byte;
        frame_start <= ~byte_valid;
        char_idx    <= nxt_char;
        col_idx     <= nxt_col;
      end else if (byte_ready) begin
        byte_valid  <= 1'b0;
        byte_data   <= 8'h00;
        frame_start <= 1'b0;
        char_idx    <= 3'd0;
        col_idx     <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_time_glyph_streamer.sv
// tb/tb_time_glyph_streamer.sv - bench for time_glyph_streamer: three parameterisations against a frame-level model.
module tb_time_glyph_streamer;

  logic       CLK, NRST, sec_inc, byte_ready;
  logic [6:0] hr, min, sec;
  logic [7:0] bd [3];
  logic       bv [3], fs [3], fd [3], by [3];

  int checks = 0;
  int failures = 0;

  localparam int GAP [3] = '{1, 1, 0};
  localparam int LZ  [3] = '{1, 0, 1};

`ifdef COLON_BLINK_EN
  localparam logic [39:0] COLON_ODD = 40'h0000000000;
`else
  localparam logic [39:0] COLON_ODD = 40'h0036360000;
`endif

  time_glyph_streamer #(.GAP_COLS(1), .LEADING_ZERO(1)) dut0 (
    .CLK(CLK), .NRST(NRST), .sec_inc(sec_inc), .hr(hr), .min(min), .sec(sec),
    .byte_ready(byte_ready), .byte_data(bd[0]), .byte_valid(bv[0]),
    .frame_start(fs[0]), .frame_done(fd[0]), .busy(by[0]));
  time_glyph_streamer #(.GAP_COLS(1), .LEADING_ZERO(0)) dut1 (
    .CLK(CLK), .NRST(NRST), .sec_inc(sec_inc), .hr(hr), .min(min), .sec(sec),
    .byte_ready(byte_ready), .byte_data(bd[1]), .byte_valid(bv[1]),
    .frame_start(fs[1]), .frame_done(fd[1]), .busy(by[1]));
  time_glyph_streamer #(.GAP_COLS(0), .LEADING_ZERO(1)) dut2 (
    .CLK(CLK), .NRST(NRST), .sec_inc(sec_inc), .hr(hr), .min(min), .sec(sec),
    .byte_ready(byte_ready), .byte_data(bd[2]), .byte_valid(bv[2]),
    .frame_start(fs[2]), .frame_done(fd[2]), .busy(by[2]));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: a frame is a byte array; timing is a countdown plus handshake consumption.
  logic [7:0] m_frame [3][64];
  int         m_len [3], m_idx [3], m_wait [3];
  bit         m_active [3], m_done [3], m_pend [3];

  function automatic logic [39:0] font(input int g);
    case (g)
      0: font = 40'h3E5149453E;  1: font = 40'h00427F4000;
      2: font = 40'h4261514946;  3: font = 40'h2141454B31;
      4: font = 40'h1814127F10;  5: font = 40'h2745454539;
      6: font = 40'h3C4A494930;  7: font = 40'h0171090503;
      8: font = 40'h3649494936;  9: font = 40'h064949291E;
      10: font = 40'h0036360000; 11: font = 40'h0808080808;
      default: font = 40'h0;
    endcase
  endfunction

  function automatic void build(input int i, input int h, input int m, input int s);
    int f [3];
    int g [8];
    int n;
    logic [39:0] gl;
    f = '{h, m, s};
    for (int k = 0; k < 3; k++) begin
      if (f[k] >= 100) begin
        g[3*k] = 11; g[3*k+1] = 11;
      end else begin
        g[3*k] = f[k] / 10; g[3*k+1] = f[k] % 10;
      end
    end
    if (LZ[i] == 0 && h < 10) g[0] = 12;
`ifdef COLON_BLINK_EN
    g[2] = (s % 2 == 1) ? 12 : 10;
`else
    g[2] = 10;
`endif
    g[5] = g[2];
    n = 0;
    for (int c = 0; c < 8; c++) begin
      gl = font(g[c]);
      for (int col = 0; col < 5; col++) begin
        m_frame[i][n] = gl[39-8*col -: 8];
        n++;
      end
      for (int gp = 0; gp < GAP[i]; gp++) begin
        m_frame[i][n] = 8'h00;
        n++;
      end
    end
    m_len[i] = n;
  endfunction

  always @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      for (int i = 0; i < 3; i++) begin
        m_active[i] = 0; m_done[i] = 0; m_pend[i] = 0; m_wait[i] = 0; m_idx[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!(m_active[i] || m_done[i])) begin
          if (sec_inc || m_pend[i]) begin
            build(i, hr, min, sec);
            m_pend[i] = 0; m_active[i] = 1; m_wait[i] = 11; m_idx[i] = 0;
          end
        end else begin
          if (sec_inc) m_pend[i] = 1;
          if (m_done[i]) m_done[i] = 0;
          else if (m_wait[i] > 0) m_wait[i]--;
          else if (byte_ready) begin
            m_idx[i]++;
            if (m_idx[i] == m_len[i]) begin
              m_active[i] = 0; m_done[i] = 1;
            end
          end
        end
      end
    end
  end

  logic [7:0] cap [3][64];
  int         cap_n [3], fs_cnt [3], done_cnt [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit ev;
    for (int i = 0; i < 3; i++) begin
      ev = m_active[i] && m_wait[i] == 0;
      chk($sformatf("byte_valid%0d", i), bv[i], ev);
      chk($sformatf("frame_start%0d", i), fs[i], ev && m_idx[i] == 0);
      chk($sformatf("frame_done%0d", i), fd[i], m_done[i]);
      chk($sformatf("busy%0d", i), by[i], m_active[i] || m_done[i]);
      if (ev) chk($sformatf("byte_data%0d", i), bd[i], m_frame[i][m_idx[i]]);
    end
  endtask

  task automatic capture();
    for (int i = 0; i < 3; i++) begin
      if (bv[i] && byte_ready) begin
        if (fs[i]) begin
          cap_n[i] = 0;
          fs_cnt[i]++;
        end
        if (cap_n[i] < 64) cap[i][cap_n[i]] = bd[i];
        cap_n[i]++;
      end
      if (fd[i]) done_cnt[i]++;
    end
  endtask

  task automatic step();
    @(negedge CLK);
    compare_all();
    capture();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((by[0] || by[1] || by[2] || m_pend[0] || m_pend[1] || m_pend[2]) && n < 600) begin
      step();
      n++;
    end
    chk("idle_timeout", n < 600, 1);
  endtask

  task automatic run_frame(input int h, input int m, input int s, output int lat);
    hr = 7'(h); min = 7'(m); sec = 7'(s);
    byte_ready = 1'b1;
    sec_inc = 1'b1;
    step();
    sec_inc = 1'b0;
    lat = 0;
    while (!bv[0] && lat < 40) begin
      step();
      lat++;
    end
    wait_idle();
  endtask

  task automatic chk_cols(input string nm, input int i, input int start, input logic [39:0] exp);
    for (int k = 0; k < 5; k++)
      chk($sformatf("%s[%0d]", nm, start + k), cap[i][start+k], exp[39-8*k -: 8]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n, fs0, d0;
    NRST = 1'b1; sec_inc = 1'b0; byte_ready = 1'b0; hr = '0; min = '0; sec = '0;
    #2 NRST = 1'b0;
    @(posedge CLK); #1;
    chk("reset_busy", by[0], 0);
    chk("reset_valid", bv[0], 0);
    chk("reset_data", bd[0], 0);
    chk("reset_done", fd[0], 0);
    step(); step();
    NRST = 1'b1;
    step(); step();

    fs0 = fs_cnt[0]; d0 = done_cnt[0];
    run_frame(12, 34, 56, lat);
    chk("latency", lat, 11);
    chk("len_gap1", cap_n[0], 48);
    chk("len_gap0", cap_n[2], 40);
    chk("frame_starts", fs_cnt[0] - fs0, 1);
    chk("frame_dones", done_cnt[0] - d0, 1);
    chk_cols("hr_one", 0, 0, 40'h00427F4000);
    chk("gap5", cap[0][5], 0);
    chk_cols("colon", 0, 12, 40'h0036360000);
    chk("gap17", cap[0][17], 0);

    run_frame(7, 0, 9, lat);
    chk_cols("blank_h1", 1, 0, 40'h0000000000);
    chk_cols("seven", 1, 6, 40'h0171090503);
    chk_cols("nine", 1, 42, 40'h064949291E);
    chk_cols("lead_zero", 0, 0, 40'h3E5149453E);

    run_frame(100, 99, 0, lat);
    chk_cols("dash0", 0, 0, 40'h0808080808);
    chk_cols("dash1", 0, 6, 40'h0808080808);
    chk_cols("min9a", 0, 18, 40'h064949291E);
    chk_cols("min9b", 0, 24, 40'h064949291E);

    run_frame(12, 34, 57, lat);
    chk_cols("colon57a", 0, 12, COLON_ODD);
    chk_cols("colon57b", 0, 30, COLON_ODD);
    chk("len_odd", cap_n[0], 48);
    run_frame(12, 34, 58, lat);
    chk_cols("colon58a", 0, 12, 40'h0036360000);
    chk_cols("colon58b", 0, 30, 40'h0036360000);

    for (int t = 0; t < 3000; t++) begin
      byte_ready = ($urandom_range(0, 3) != 0);
      hr  = 7'($urandom_range(0, 127));
      min = 7'($urandom_range(0, 127));
      sec = 7'($urandom_range(0, 127));
      sec_inc = ($urandom_range(0, 24) == 0);
      step();
    end
    sec_inc = 1'b0; byte_ready = 1'b1;
    wait_idle();

    fs0 = fs_cnt[0]; d0 = done_cnt[0];
    hr = 7'd1; min = 7'd2; sec = 7'd3;
    sec_inc = 1'b1; step(); sec_inc = 1'b0;
    repeat (15) step();
    repeat (3) begin
      sec_inc = 1'b1; step(); sec_inc = 1'b0;
      repeat (4) step();
    end
    n = 0;
    while (!fd[0] && n < 200) begin
      step();
      n++;
    end
    chk("done_timeout", n < 200, 1);
    step();
    chk("busy_gap", by[0], 0);
    step();
    chk("busy_restart", by[0], 1);
    wait_idle();
    chk("coalesced_frames", fs_cnt[0] - fs0, 2);
    chk("coalesced_dones", done_cnt[0] - d0, 2);

    byte_ready = 1'b1;
    sec_inc = 1'b1; step(); sec_inc = 1'b0;
    n = 0;
    while (cap_n[0] != 20 && n < 100) begin
      step();
      n++;
    end
    chk("byte20_timeout", n < 100, 1);
    d0 = done_cnt[0];
    #1 NRST = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_valid%0d", i), bv[i], 0);
      chk($sformatf("arst_data%0d", i), bd[i], 0);
      chk($sformatf("arst_start%0d", i), fs[i], 0);
      chk($sformatf("arst_done%0d", i), fd[i], 0);
      chk($sformatf("arst_busy%0d", i), by[i], 0);
    end
    step(); step();
    NRST = 1'b1;
    step(); step(); step();
    chk("no_done_after_reset", done_cnt[0] - d0, 0);
    run_frame(21, 43, 5, lat);
    chk("latency_after_reset", lat, 11);
    chk("len_after_reset", cap_n[0], 48);
    chk_cols("two_after_reset", 0, 0, 40'h4261514946);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_glyph_streamer.md
Name: time_glyph_streamer

Overview:
- Sits directly downstream of clock_driver and upstream of the I2C data path (i2c_oled_setup data source).
- On each seconds tick it snapshots hr/min/sec and converts each field to two decimal digits, using sequential conversion.
- Renders the text "HH:MM:SS" as OLED column bytes from a fixed 5x7 font.
- Streams the bytes one at a time over a valid/ready handshake so the I2C master can send them as GDDRAM data.

Parameters:
- GAP_COLS, 1, blank 0x00 columns appended after each glyph; legal range 0..3.
- LEADING_ZERO, 1, 1 = hour tens digit 0 drawn as '0'; 0 = drawn as blank glyph.

Ports:
- CLK  input  1  system clock.
- NRST  input  1  asynchronous active-low reset.
- sec_inc  input  1  one-cycle tick from seconds_clock; requests a new frame.
- hr  input  7  hours from clock_driver, binary.
- min  input  7  minutes from clock_driver, binary.
- sec  input  7  seconds from clock_driver, binary.
- byte_ready  input  1  consumer accepts byte_data on this cycle when byte_valid=1.
- byte_data  output  8  font column; LSB = top pixel row.
- byte_valid  output  1  byte_data is valid.
- frame_start  output  1  high together with byte_valid on byte 0 of a frame only.
- frame_done  output  1  one-cycle pulse after the last byte is accepted.
- busy  output  1  frame in progress, CONVERT through DONE.

Behaviour:
- Clock and reset: one clock, CLK. NRST is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, pending flag 0, byte counter 0, snapshot registers 0.
- States: IDLE -> CONVERT -> STREAM -> DONE -> IDLE.
- IDLE:
  - On sec_inc=1 (or pending=1), latch hr/min/sec into snapshot registers, clear pending, go to CONVERT.
  - The snapshot is taken on the same edge as the sec_inc sample.
- CONVERT: exactly 10 cycles.
  - Runs three parallel repeated-subtract-10 units, one per field.
  - Each unit's tens count saturates at 9.
  - Fixed latency: sec_inc sampled at edge N -> byte_valid=1 after edge N+11.
- Range rule: any field >= 100 renders as two '-' glyphs. Values 60..99 are not range-checked and render literally.
- Character order, left to right: H1 H0 ':' M1 M0 ':' S1 S0.
- Byte order:
  - Each character sends 5 font columns, column 0 first, then GAP_COLS bytes of 0x00.
  - Frame length is 8*(5+GAP_COLS) bytes; 48 at default.
- Font (column bytes):
  - '0' = 3E 51 49 45 3E
  - '1' = 00 42 7F 40 00
  - '2' = 42 61 51 49 46
  - '3' = 21 41 45 4B 31
  - '4' = 18 14 12 7F 10
  - '5' = 27 45 45 45 39
  - '6' = 3C 4A 49 49 30
  - '7' = 01 71 09 05 03
  - '8' = 36 49 49 49 36
  - '9' = 06 49 49 29 1E
  - ':' = 00 36 36 00 00
  - '-' = 08 08 08 08 08
  - blank = 00 00 00 00 00
- STREAM:
  - byte_valid=1 continuously.
  - byte_data and frame_start hold stable while byte_valid=1 and byte_ready=0.
  - The byte counter advances only on byte_valid && byte_ready.
  - Acceptance of the last byte -> DONE.
  - byte_valid never drops mid-frame.
- DONE:
  - frame_done=1 for exactly one cycle, byte_valid=0.
  - Then IDLE. If pending=1, IDLE starts a new frame on the next cycle.
- sec_inc while busy: sets pending. Multiple ticks coalesce into one pending frame.
- The snapshot is immutable during a frame. hr/min/sec changing mid-frame has no effect.
- busy is low only in IDLE.
- NRST asserted mid-frame: immediate return to reset values. No frame_done. Pending is lost.

Optional Feature:
- Macro: COLON_BLINK_EN.
- Defined: both ':' glyphs render as blank when snapshot sec bit 0 = 1 (odd seconds).
- Undefined: colons are always drawn.
- Frame length and timing are identical in both cases.

Test Plan:
- Reset then hr=12, min=34, sec=56, one sec_inc, byte_ready=1 ->
  - bytes 0-5 = 00 42 7F 40 00 00 ('1', gap).
  - bytes 12-17 = 00 36 36 00 00 00 (':').
  - 48 bytes total; frame_start on byte 0 only.
  - frame_done one cycle after byte 47; first byte_valid 11 cycles after the sec_inc edge.
- LEADING_ZERO=0, hr=7, min=0, sec=9 ->
  - bytes 0-4 = 00 (blank H1).
  - bytes 6-10 = 01 71 09 05 03 ('7').
  - bytes 42-46 = 06 49 49 29 1E ('9').
- hr=100, min=99, sec=0 -> bytes 0-10 show '-', '-' (08 08 08 08 08 each); minute digits render '9', '9'.
- byte_ready toggling pseudo-randomly; hr/min/sec changed mid-frame -> byte_data stable while stalled; byte sequence identical to the no-stall run; snapshot values used.
- Three sec_inc pulses during one frame -> exactly one extra frame starts one cycle after frame_done; busy low for exactly that one IDLE cycle.
- NRST low at byte 20 -> outputs 0 asynchronously; no frame_done. Next sec_inc gives a full 48-byte frame starting at byte 0.
- COLON_BLINK_EN defined, sec=57 -> bytes 12-16 and 30-34 are 00. With sec=58 those bytes are 00 36 36 00 00.
